// File: rtl/pipe_block_source.sv
// Block-oriented word source: sends xfer_words (rounded down to whole blocks) as
// strobe-announced bursts of BLOCK_WORDS words, with selectable data generator.
module pipe_block_source #(
   parameter int unsigned BLOCK_WORDS = 256,
   parameter int unsigned GAP_CYCLES  = 0
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        start,
   input  logic [31:0] xfer_words,
   input  logic [2:0]  pattern,
   input  logic [31:0] fixed_pattern,
   input  logic        ep_ready,
   output logic        ep_blockstrobe,
   output logic        ep_write,
   output logic [31:0] ep_dataout,
   output logic        busy,
   output logic        done,
   output logic [31:0] words_sent
);

   localparam int unsigned            WordBits = $clog2(BLOCK_WORDS);
   localparam logic [31:0]            LfsrSeed = 32'h0D0C0B0A;
   localparam logic [WordBits-1:0]    LastWord = WordBits'(BLOCK_WORDS - 1);
   localparam logic [7:0]             GapLast  = 8'(GAP_CYCLES - 1);

   typedef enum logic [2:0] {StIdle, StWaitReady, StStrobe, StBurst, StGap} state_e;

   state_e               state_q, state_d;
   logic [31:0]          blocks_q, blocks_d;
   logic [WordBits-1:0]  word_cnt_q, word_cnt_d;
   logic [7:0]           gap_cnt_q, gap_cnt_d;
   logic [31:0]          gen_q, gen_d;
   logic [2:0]           pattern_q, pattern_d;
   logic [31:0]          fixed_q, fixed_d;
   logic [31:0]          words_sent_q, words_sent_d;
   logic                 busy_q, busy_d;
   logic                 done_q, done_d;
   logic                 strobe_q, strobe_d;
   logic                 write_q, write_d;
   logic [31:0]          dataout_q, dataout_d;

   // First word of a transfer for the given pattern; patterns 3..7 alias the LFSR.
   function automatic logic [31:0] gen_seed(input logic [2:0] pat, input logic [31:0] fix);
      case (pat)
         3'd1:    return 32'd1;
         3'd2:    return fix;
         default: return LfsrSeed;
      endcase
   endfunction

   // Successor of the current generator word.
   function automatic logic [31:0] gen_next(input logic [2:0] pat, input logic [31:0] cur,
                                            input logic [31:0] fix);
      case (pat)
         3'd1:    return cur + 32'd1;
         3'd2:    return fix;
         default: return {cur[30:0], cur[31] ^ cur[21] ^ cur[1] ^ cur[0]};
      endcase
   endfunction

   // Next-state and next-output logic; every output is a registered copy of its _d.
   always_comb begin
      state_d      = state_q;
      blocks_d     = blocks_q;
      word_cnt_d   = word_cnt_q;
      gap_cnt_d    = gap_cnt_q;
      gen_d        = gen_q;
      pattern_d    = pattern_q;
      fixed_d      = fixed_q;
      words_sent_d = words_sent_q;
      busy_d       = busy_q;
      done_d       = 1'b0;
      strobe_d     = 1'b0;
      write_d      = 1'b0;
      dataout_d    = 32'd0;

      unique case (state_q)
         StIdle: begin
            if (start) begin
               pattern_d    = pattern;
               fixed_d      = fixed_pattern;
               gen_d        = gen_seed(pattern, fixed_pattern);
               words_sent_d = 32'd0;
               if ((xfer_words >> WordBits) != 32'd0) begin
                  blocks_d = xfer_words >> WordBits;
                  busy_d   = 1'b1;
                  state_d  = StWaitReady;
               end else begin
                  // Less than one whole block: complete immediately without writing.
                  done_d = 1'b1;
               end
            end
         end
         StWaitReady: begin
            if (ep_ready) begin
               strobe_d = 1'b1;
               state_d  = StStrobe;
            end
         end
         StStrobe: begin
            write_d      = 1'b1;
            dataout_d    = gen_q;
            gen_d        = gen_next(pattern_q, gen_q, fixed_q);
            words_sent_d = words_sent_q + 32'd1;
            word_cnt_d   = '0;
            state_d      = StBurst;
         end
         StBurst: begin
            // word_cnt_q indexes the word currently on ep_dataout.
            if (word_cnt_q == LastWord) begin
               blocks_d = blocks_q - 32'd1;
               if (blocks_q == 32'd1) begin
                  busy_d  = 1'b0;
                  done_d  = 1'b1;
                  state_d = StIdle;
               end else if (GAP_CYCLES == 0) begin
                  state_d = StWaitReady;
               end else begin
                  gap_cnt_d = GapLast;
                  state_d   = StGap;
               end
            end else begin
               write_d      = 1'b1;
               dataout_d    = gen_q;
               gen_d        = gen_next(pattern_q, gen_q, fixed_q);
               words_sent_d = words_sent_q + 32'd1;
               word_cnt_d   = word_cnt_q + WordBits'(1);
            end
         end
         StGap: begin
            if (gap_cnt_q == 8'd0) begin
               state_d = StWaitReady;
            end else begin
               gap_cnt_d = gap_cnt_q - 8'd1;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // State and output registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q      <= StIdle;
         blocks_q     <= 32'd0;
         word_cnt_q   <= '0;
         gap_cnt_q    <= 8'd0;
         gen_q        <= LfsrSeed;
         pattern_q    <= 3'd0;
         fixed_q      <= 32'd0;
         words_sent_q <= 32'd0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         strobe_q     <= 1'b0;
         write_q      <= 1'b0;
         dataout_q    <= 32'd0;
      end else begin
         state_q      <= state_d;
         blocks_q     <= blocks_d;
         word_cnt_q   <= word_cnt_d;
         gap_cnt_q    <= gap_cnt_d;
         gen_q        <= gen_d;
         pattern_q    <= pattern_d;
         fixed_q      <= fixed_d;
         words_sent_q <= words_sent_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
         strobe_q     <= strobe_d;
         write_q      <= write_d;
         dataout_q    <= dataout_d;
      end
   end

   assign ep_blockstrobe = strobe_q;
   assign ep_write       = write_q;
   assign ep_dataout     = dataout_q;
   assign busy           = busy_q;
   assign done           = done_q;
   assign words_sent     = words_sent_q;

endmodule

// File: tb/tb_pipe_block_source.sv
// Self-checking bench for pipe_block_source (BLOCK_WORDS=4, GAP_CYCLES=2).
module tb_pipe_block_source;

   localparam int unsigned BW  = 4;
   localparam int unsigned GAP = 2;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        start;
   logic [31:0] xfer_words;
   logic [2:0]  pattern;
   logic [31:0] fixed_pattern;
   logic        ep_ready;
   logic        ep_blockstrobe;
   logic        ep_write;
   logic [31:0] ep_dataout;
   logic        busy;
   logic        done;
   logic [31:0] words_sent;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   pipe_block_source #(
      .BLOCK_WORDS(BW),
      .GAP_CYCLES (GAP)
   ) dut (
      .clk           (clk),
      .reset_n       (reset_n),
      .start         (start),
      .xfer_words    (xfer_words),
      .pattern       (pattern),
      .fixed_pattern (fixed_pattern),
      .ep_ready      (ep_ready),
      .ep_blockstrobe(ep_blockstrobe),
      .ep_write      (ep_write),
      .ep_dataout    (ep_dataout),
      .busy          (busy),
      .done          (done),
      .words_sent    (words_sent)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   task automatic chk1(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   // Inputs are driven before the edge; outputs are sampled 1ns after it.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Reference data sequence, straight from the pattern rules.
   function automatic logic [31:0] m_first(input logic [2:0] pat, input logic [31:0] fix);
      if (pat == 3'd1) return 32'h0000_0001;
      if (pat == 3'd2) return fix;
      return 32'h0D0C_0B0A;
   endfunction

   function automatic logic [31:0] m_next(input logic [2:0] pat, input logic [31:0] d,
                                          input logic [31:0] fix);
      if (pat == 3'd1) return d + 32'd1;
      if (pat == 3'd2) return fix;
      return {d[30:0], d[31] ^ d[21] ^ d[1] ^ d[0]};
   endfunction

   // Random start pulses and parameter changes while busy; all must be ignored.
   task automatic noise(input bit en);
      if (en) begin
         start         = 1'($urandom_range(1));
         xfer_words    = $urandom;
         pattern       = 3'($urandom_range(7));
         fixed_pattern = $urandom;
      end
   endtask

   task automatic chk_quiet(input string tag);
      chk1({tag, "_strobe"}, ep_blockstrobe, 1'b0);
      chk1({tag, "_write"}, ep_write, 1'b0);
      chk({tag, "_data"}, ep_dataout, 32'd0);
   endtask

   // One complete transfer, stepping and checking every cycle against the model.
   task automatic run_xfer(input logic [31:0] words, input logic [2:0] pat,
                           input logic [31:0] fix, input int ready_pct, input int min_wait,
                           input bit nz);
      int          nblk;
      int          sent;
      int          waited;
      bit          rdy;
      logic [31:0] exp_d;
      start         = 1'b1;
      xfer_words    = words;
      pattern       = pat;
      fixed_pattern = fix;
      ep_ready      = 1'($urandom_range(1));
      step();
      start = 1'b0;
      nblk  = int'(words / BW);
      if (nblk == 0) begin
         chk1("short_done", done, 1'b1);
         chk1("short_busy", busy, 1'b0);
         chk_quiet("short");
         step();
         chk1("short_done_clr", done, 1'b0);
         chk1("short_busy2", busy, 1'b0);
         chk_quiet("short2");
         return;
      end
      chk1("start_busy", busy, 1'b1);
      chk1("start_done", done, 1'b0);
      chk("start_ws", words_sent, 32'd0);
      chk_quiet("start");
      exp_d = m_first(pat, fix);
      sent  = 0;
      for (int b = 0; b < nblk; b++) begin
         waited = 0;
         rdy    = 1'b0;
         while (!rdy) begin
            if (b == 0 && waited < min_wait) rdy = 1'b0;
            else rdy = ($urandom_range(99) < ready_pct) || (waited >= 50);
            ep_ready = rdy;
            noise(nz);
            step();
            waited++;
            chk1("wait_strobe", ep_blockstrobe, rdy);
            chk1("wait_write", ep_write, 1'b0);
            chk1("wait_busy", busy, 1'b1);
         end
         for (int w = 0; w < int'(BW); w++) begin
            ep_ready = 1'($urandom_range(1));
            noise(nz);
            step();
            sent++;
            chk1("burst_write", ep_write, 1'b1);
            chk("burst_data", ep_dataout, exp_d);
            chk("burst_ws", words_sent, 32'(sent));
            chk1("burst_strobe", ep_blockstrobe, 1'b0);
            exp_d = m_next(pat, exp_d, fix);
         end
         if (b != nblk - 1) begin
            // GAP cycles of silence, then the first WAIT_READY cycle.
            for (int g = 0; g <= int'(GAP); g++) begin
               ep_ready = 1'($urandom_range(1));
               noise(nz);
               step();
               chk_quiet("gap");
               chk1("gap_busy", busy, 1'b1);
               chk1("gap_done", done, 1'b0);
            end
         end
      end
      start    = 1'b0;
      ep_ready = 1'($urandom_range(1));
      step();
      chk1("end_done", done, 1'b1);
      chk1("end_busy", busy, 1'b0);
      chk_quiet("end");
      chk("end_ws", words_sent, 32'(sent));
      step();
      chk1("end_done_clr", done, 1'b0);
      chk("end_ws_hold", words_sent, 32'(sent));
   endtask

   initial begin
      reset_n       = 1'b0;
      start         = 1'b0;
      xfer_words    = 32'd0;
      pattern       = 3'd0;
      fixed_pattern = 32'd0;
      ep_ready      = 1'b0;
      step();
      step();
      chk_quiet("rst");
      chk1("rst_busy", busy, 1'b0);
      chk1("rst_done", done, 1'b0);
      chk("rst_ws", words_sent, 32'd0);
      reset_n = 1'b1;
      step();
      chk_quiet("idle");

      // Two-block counter transfer with the inter-block gap.
      run_xfer(32'd8, 3'd1, 32'd0, 100, 0, 1'b0);
      // LFSR sequence for a single block.
      run_xfer(32'd4, 3'd0, 32'd0, 100, 0, 1'b0);
      // Sink not ready for 10 cycles.
      run_xfer(32'd8, 3'd0, 32'd0, 100, 10, 1'b0);
      // Fewer words than a block: immediate done.
      run_xfer(32'd3, 3'd1, 32'd0, 100, 0, 1'b0);
      // Fixed pattern and an aliased LFSR pattern; low bits of xfer_words dropped.
      run_xfer(32'd7, 3'd2, 32'hCAFE_F00D, 70, 0, 1'b0);
      run_xfer(32'd12, 3'd6, 32'd0, 60, 0, 1'b0);
      // Start re-pulsed with other parameters mid-transfer.
      run_xfer(32'd8, 3'd1, 32'd0, 100, 0, 1'b1);

      // Reset during the third word of a burst.
      start         = 1'b1;
      xfer_words    = 32'd8;
      pattern       = 3'd1;
      fixed_pattern = 32'd0;
      ep_ready      = 1'b1;
      step();
      start = 1'b0;
      step();
      chk1("rb_strobe", ep_blockstrobe, 1'b1);
      step();
      step();
      step();
      chk("rb_word3", ep_dataout, 32'd3);
      reset_n = 1'b0;
      step();
      chk_quiet("rb_rst");
      chk1("rb_busy", busy, 1'b0);
      chk1("rb_done", done, 1'b0);
      chk("rb_ws", words_sent, 32'd0);
      step();
      chk_quiet("rb_rst2");
      reset_n = 1'b1;
      for (int i = 0; i < 6; i++) begin
         step();
         chk_quiet("rb_noresume");
         chk1("rb_noresume_busy", busy, 1'b0);
      end
      run_xfer(32'd4, 3'd1, 32'd0, 100, 0, 1'b0);

      // Randomized transfers with random ready and spurious starts.
      for (int t = 0; t < 24; t++) begin
         run_xfer(32'($urandom_range(22)), 3'($urandom_range(7)), $urandom,
                  int'($urandom_range(100, 20)), 0, 1'b1);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/pipe_block_source.md
PIPE_BLOCK_SOURCE -- requirements
Module: pipe_block_source

Interface
REQ-001 SHALL have parameter BLOCK_WORDS, default 256: words per block; power of two, 2..1024.
REQ-002 SHALL have parameter GAP_CYCLES, default 0: idle cycles inserted between blocks; range 0..255.
REQ-003 SHALL have port clk  input  1  the single clock; all logic on its rising edge.
REQ-004 SHALL have port reset_n  input  1  reset, synchronous and active-low.
REQ-005 SHALL have port start  input  1  single-cycle transfer request, sampled only in IDLE.
REQ-006 SHALL have port xfer_words  input  32  total words to send, latched on an accepted start.
REQ-007 SHALL have port pattern  input  3  data source select, latched on an accepted start.
REQ-008 SHALL have port fixed_pattern  input  32  constant word used when pattern=2, latched on an accepted start.
REQ-009 SHALL have port ep_ready  input  1  sink can accept one full block.
REQ-010 SHALL have port ep_blockstrobe  output  1  one-cycle pulse announcing a block.
REQ-011 SHALL have port ep_write  output  1  data-valid strobe, one word per cycle.
REQ-012 SHALL have port ep_dataout  output  32  write data, valid when ep_write=1.
REQ-013 SHALL have port busy  output  1  transfer in progress.
REQ-014 SHALL have port done  output  1  one-cycle completion pulse.
REQ-015 SHALL have port words_sent  output  32  count of words written since the last accepted start.

Function
REQ-016 SHALL register all outputs; the FSM states SHALL be IDLE, WAIT_READY, STROBE, BURST and GAP.
REQ-017 SHALL compute block count as floor(xfer_words / BLOCK_WORDS) and ignore the low log2(BLOCK_WORDS) bits of xfer_words.
REQ-018 In IDLE, a start with block count > 0 SHALL enter WAIT_READY next cycle, set busy=1, clear words_sent and reseed the generator.
REQ-019 In IDLE, a start with block count = 0 SHALL pulse done for one cycle at the next edge, with no writes; the FSM SHALL stay in IDLE.
REQ-020 SHALL ignore start when not in IDLE, with no effect on the latched parameters.
REQ-021 In WAIT_READY, ep_ready=1 sampled at an edge SHALL move to STROBE; ep_blockstrobe=1 during the STROBE cycle only.
REQ-022 STROBE SHALL always be followed by BURST.
REQ-023 BURST SHALL assert ep_write for exactly BLOCK_WORDS consecutive cycles regardless of ep_ready.
REQ-024 SHALL increment words_sent and advance the generator once per written word.
REQ-025 After the last word of a block, with blocks remaining, SHALL enter GAP for GAP_CYCLES cycles and then WAIT_READY; GAP_CYCLES=0 SHALL go directly to WAIT_READY.
REQ-026 After the last word of the last block SHALL go to IDLE, clear busy and pulse done in the first IDLE cycle.
REQ-027 With pattern=0, data SHALL be a 32-bit LFSR: first word 0x0D0C0B0A; next = {d[30:0], d[31]^d[21]^d[1]^d[0]}.
REQ-028 With pattern=1, data SHALL be an incrementing counter starting at 0x00000001 and wrapping from 0xFFFFFFFF to 0x00000000.
REQ-029 With pattern=2, every word SHALL equal the latched fixed_pattern.
REQ-030 With pattern=3..7, the block SHALL behave as pattern=0.
REQ-031 The generator SHALL continue across block boundaries, with no reseed between blocks.
REQ-032 ep_dataout SHALL be 0 whenever ep_write=0.

Reset
REQ-033 reset_n=0 at an edge SHALL force IDLE and set ep_write, ep_blockstrobe, ep_dataout, busy, done and words_sent to 0, including mid-burst.
REQ-034 After reset the generator SHALL be reseeded and latched parameters cleared; a truncated block SHALL NOT be resumed.

Verification
REQ-035 BLOCK_WORDS=4, GAP_CYCLES=2, xfer_words=8, pattern=1, ep_ready=1 -> strobe; data 1,2,3,4; 2 idle cycles; strobe; data 5,6,7,8; done pulse; words_sent=8.
REQ-036 pattern=0, one block -> first two words 0x0D0C0B0A, 0x1A181615.
REQ-037 ep_ready=0 for 10 cycles after start -> no strobe and no write, busy=1; ep_ready=1 -> strobe one cycle later, then the burst.
REQ-038 BLOCK_WORDS=4, xfer_words=3 -> done pulse one cycle after start; ep_write never asserted; busy stays 0.
REQ-039 reset_n=0 for 2 cycles during the 3rd word of a burst -> all outputs 0 at the next edge; a new start with pattern=1 gives first word 0x00000001.
REQ-040 start re-pulsed with different xfer_words mid-transfer -> ignored; original word count completes.
